// File: rtl/rv32_wb_arbiter.sv
// rv32_wb_arbiter
//
// Write-back arbiter and load formatter in front of the register file
// write port. Two producers hand over completed results:
//   - the single-cycle ALU path (alu_*), and
//   - the load/store unit (lsu_*), whose raw memory word is aligned and
//     sign/zero-extended here according to the load type.
// One result is accepted per cycle. The accepted result is registered and
// presented as we_o/waddr_o/wdata_o during the following cycle.
//
// Handshake: a transfer on a source happens at a rising clk_i edge where
// its valid and ready are both high. Ready never depends on the same
// source's own valid (it may depend on the other source's valid and on the
// starvation counter). A source holds valid and payload stable until its
// transfer. The register file never back-pressures.
//
// Ports:
//   clk_i, rst_n                  clock, asynchronous active-low reset
//   alu_valid_i/alu_ready_o       ALU result handshake
//   alu_rd_i, alu_data_i          ALU destination register and result
//   lsu_valid_i/lsu_ready_o       load result handshake
//   lsu_rd_i, lsu_data_i          load destination and raw memory word
//   lsu_funct3_i                  load type (LB/LH/LW/LBU/LHU)
//   lsu_addr_lo_i                 byte offset of the load address
//   we_o, waddr_o, wdata_o        registered register file write port
//   starve_cnt_o                  debug view of the ALU starvation counter

module rv32_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              alu_valid_i,
  output logic              alu_ready_o,
  input  logic [ADDR_W-1:0] alu_rd_i,
  input  logic [XLEN-1:0]   alu_data_i,
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic [ADDR_W-1:0] lsu_rd_i,
  input  logic [XLEN-1:0]   lsu_data_i,
  input  logic [2:0]        lsu_funct3_i,
  input  logic [1:0]        lsu_addr_lo_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [CNT_W-1:0]  starve_cnt_o
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_nxt;
  logic             alu_prio;
  logic             alu_fire;
  logic             lsu_fire;

  // The LSU normally wins; once the ALU has lost STARVE_MAX cycles in a
  // row it wins the next cycle outright.
  assign alu_prio    = (starve_cnt == STARVE_LIM);
  assign lsu_ready_o = !(alu_prio && alu_valid_i);
  assign alu_ready_o = !lsu_valid_i || alu_prio;

  // The two ready terms above make these mutually exclusive.
  assign alu_fire = alu_valid_i && alu_ready_o;
  assign lsu_fire = lsu_valid_i && lsu_ready_o;

  // Counts consecutive cycles in which a waiting ALU result was refused.
  // Any cycle where the ALU is idle or transfers restarts the count.
  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (alu_valid_i && !alu_ready_o) begin
      if (starve_cnt != STARVE_LIM) begin
        starve_cnt_nxt = starve_cnt + 1'b1;
      end
    end else begin
      starve_cnt_nxt = '0;
    end
  end

  assign starve_cnt_o = starve_cnt;

  // ---------------------------------------------------------------------
  // Load formatting
  // ---------------------------------------------------------------------
  logic [7:0]      byte_lane;
  logic [15:0]     half_lane;
  logic [XLEN-1:0] load_data;

  always_comb begin
    byte_lane = lsu_data_i[7:0];
    case (lsu_addr_lo_i)
      2'd0:    byte_lane = lsu_data_i[7:0];
      2'd1:    byte_lane = lsu_data_i[15:8];
      2'd2:    byte_lane = lsu_data_i[23:16];
      default: byte_lane = lsu_data_i[31:24];
    endcase
  end

  // Offset bit 0 is don't-care for halfwords: misaligned loads never get
  // this far.
  assign half_lane = lsu_addr_lo_i[1] ? lsu_data_i[31:16] : lsu_data_i[15:0];

  always_comb begin
    load_data = lsu_data_i;
    case (lsu_funct3_i)
      F3_LB:   load_data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      F3_LH:   load_data = {{(XLEN-16){half_lane[15]}}, half_lane};
      F3_LBU:  load_data = {{(XLEN-8){1'b0}}, byte_lane};
      F3_LHU:  load_data = {{(XLEN-16){1'b0}}, half_lane};
      // LW and undefined codes pass the word through.
      default: load_data = lsu_data_i;
    endcase
  end

  // ---------------------------------------------------------------------
  // Winner select and output register
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] win_rd;
  logic [XLEN-1:0]   win_data;

  always_comb begin
    win_rd   = alu_rd_i;
    win_data = alu_data_i;
    if (lsu_fire) begin
      win_rd   = lsu_rd_i;
      win_data = load_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      we_o       <= 1'b0;
      waddr_o    <= '0;
      wdata_o    <= '0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      we_o       <= 1'b0;
      if (alu_fire || lsu_fire) begin
        // A result for x0 is consumed but never written.
        we_o    <= (win_rd != '0);
        waddr_o <= win_rd;
        wdata_o <= win_data;
      end
    end
  end

endmodule

// File: tb/tb_rv32_wb_arbiter.sv
// Testbench for rv32_wb_arbiter: fixed vector table, hand-written
// starvation and reset sequences, then randomized traffic against a
// reference model of the write-back rules.

module tb_rv32_wb_arbiter;

  localparam int XLEN       = 32;
  localparam int ADDR_W     = 5;
  localparam int STARVE_MAX = 4;
  localparam int CNT_W      = 3;
  localparam int N_RAND     = 400;

  // -------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic              alu_v, alu_rdy;
  logic [ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]   alu_d;
  logic              lsu_v, lsu_rdy;
  logic [ADDR_W-1:0] lsu_rd;
  logic [XLEN-1:0]   lsu_d;
  logic [2:0]        f3;
  logic [1:0]        off;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [XLEN-1:0]   wdata;
  logic [CNT_W-1:0]  scnt;

  rv32_wb_arbiter #(
    .XLEN(XLEN), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_n(rst_n),
    .alu_valid_i(alu_v), .alu_ready_o(alu_rdy),
    .alu_rd_i(alu_rd), .alu_data_i(alu_d),
    .lsu_valid_i(lsu_v), .lsu_ready_o(lsu_rdy),
    .lsu_rd_i(lsu_rd), .lsu_data_i(lsu_d),
    .lsu_funct3_i(f3), .lsu_addr_lo_i(off),
    .we_o(we), .waddr_o(waddr), .wdata_o(wdata),
    .starve_cnt_o(scnt)
  );

  // -------------------------------------------------------------------
  // Checking
  // -------------------------------------------------------------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Load result per the ISA rules, using plain arithmetic.
  function automatic logic [31:0] fmt(input logic [31:0] d, input logic [2:0] fn, input logic [1:0] o);
    logic [31:0] b;
    logic [31:0] h;
    b = (d >> (8 * int'(o))) & 32'h0000_00FF;
    h = (d >> (16 * (int'(o) / 2))) & 32'h0000_FFFF;
    case (fn)
      3'b000:  return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return d;
    endcase
  endfunction

  // -------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------
  task automatic drive_idle();
    alu_v = 1'b0; alu_rd = '0; alu_d = '0;
    lsu_v = 1'b0; lsu_rd = '0; lsu_d = '0;
    f3 = 3'b010; off = 2'd0;
  endtask

  // Vector table: each entry is one cycle starting from an unstarved
  // arbiter; expectations are the readies before the edge and the write
  // port after it.
  typedef struct {
    logic              a_v;
    logic [ADDR_W-1:0] a_rd;
    logic [XLEN-1:0]   a_d;
    logic              l_v;
    logic [ADDR_W-1:0] l_rd;
    logic [XLEN-1:0]   l_d;
    logic [2:0]        l_f3;
    logic [1:0]        l_off;
    logic              e_ardy;
    logic              e_lrdy;
    logic              e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [XLEN-1:0]   e_data;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl [NV];

  // Scoreboard queue for the random phase: {we, waddr, wdata}.
  logic [1+ADDR_W+XLEN-1:0] exp_q[$];

  initial begin
    logic [1+ADDR_W+XLEN-1:0] e;
    logic a_pend, l_pend, prio, e_ardy, e_lrdy, a_win, l_win;
    logic [ADDR_W-1:0] h_addr;
    logic [XLEN-1:0]   h_data;
    int lost;

    tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 3'b010, 2'd0, 1'b1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 3'b010, 2'd0, 1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h80FF7F01, 3'b000, 2'd3, 1'b0, 1'b1, 1'b1, 5'd7, 32'hFFFFFF80};
    tbl[3]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h80FF7F01, 3'b100, 2'd3, 1'b0, 1'b1, 1'b1, 5'd7, 32'h00000080};
    tbl[4]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h80FF7F01, 3'b001, 2'd2, 1'b0, 1'b1, 1'b1, 5'd7, 32'hFFFF80FF};
    tbl[5]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h80FF7F01, 3'b101, 2'd0, 1'b0, 1'b1, 1'b1, 5'd7, 32'h00007F01};
    tbl[6]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h80FF7F01, 3'b010, 2'd0, 1'b0, 1'b1, 1'b1, 5'd7, 32'h80FF7F01};
    tbl[7]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h80FF7F01, 3'b000, 2'd0, 1'b0, 1'b1, 1'b1, 5'd8, 32'h00000001};
    tbl[8]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h80FF7F01, 3'b001, 2'd3, 1'b0, 1'b1, 1'b1, 5'd9, 32'hFFFF80FF};
    tbl[9]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h80FF7F01, 3'b011, 2'd1, 1'b0, 1'b1, 1'b1, 5'd2, 32'h80FF7F01};
    tbl[10] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 32'h80FF7F01, 3'b100, 2'd1, 1'b0, 1'b1, 1'b1, 5'd31, 32'h0000007F};
    tbl[11] = '{1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'h0, 3'b010, 2'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h12345678};
    tbl[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 3'b010, 2'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h12345678};

    // ---------------- power-on reset ----------------
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_scnt", 32'(scnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_we", 32'(we), 32'd0);

    // ---------------- vector table ----------------
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      alu_v = tbl[i].a_v; alu_rd = tbl[i].a_rd; alu_d = tbl[i].a_d;
      lsu_v = tbl[i].l_v; lsu_rd = tbl[i].l_rd; lsu_d = tbl[i].l_d;
      f3 = tbl[i].l_f3; off = tbl[i].l_off;
      #1;
      chk($sformatf("v%0d_alu_rdy", i), 32'(alu_rdy), 32'(tbl[i].e_ardy));
      chk($sformatf("v%0d_lsu_rdy", i), 32'(lsu_rdy), 32'(tbl[i].e_lrdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d_we", i), 32'(we), 32'(tbl[i].e_we));
      chk($sformatf("v%0d_waddr", i), 32'(waddr), 32'(tbl[i].e_addr));
      chk($sformatf("v%0d_wdata", i), wdata, tbl[i].e_data);
    end

    // ---------------- starvation ----------------
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    alu_v = 1'b1; alu_rd = 5'd3; alu_d = 32'hA5A5A5A5;
    lsu_v = 1'b1; lsu_rd = 5'd10; f3 = 3'b010; off = 2'd0;
    for (int k = 0; k < STARVE_MAX; k++) begin
      if (k != 0) @(negedge clk);
      lsu_d = 32'h1111_0000 + 32'(k);
      #1;
      chk($sformatf("starve%0d_alu_rdy", k), 32'(alu_rdy), 32'd0);
      chk($sformatf("starve%0d_lsu_rdy", k), 32'(lsu_rdy), 32'd1);
      chk($sformatf("starve%0d_cnt", k), 32'(scnt), 32'(k));
      @(posedge clk); #1;
      chk($sformatf("starve%0d_we", k), 32'(we), 32'd1);
      chk($sformatf("starve%0d_waddr", k), 32'(waddr), 32'd10);
      chk($sformatf("starve%0d_wdata", k), wdata, 32'h1111_0000 + 32'(k));
    end
    @(negedge clk); #1;
    chk("prio_alu_rdy", 32'(alu_rdy), 32'd1);
    chk("prio_lsu_rdy", 32'(lsu_rdy), 32'd0);
    chk("prio_cnt", 32'(scnt), 32'(STARVE_MAX));
    @(posedge clk); #1;
    chk("prio_we", 32'(we), 32'd1);
    chk("prio_waddr", 32'(waddr), 32'd3);
    chk("prio_wdata", wdata, 32'hA5A5A5A5);
    chk("prio_cnt_clr", 32'(scnt), 32'd0);
    @(negedge clk);
    alu_v = 1'b0;
    lsu_d = 32'h2222_2222;
    #1;
    chk("resume_lsu_rdy", 32'(lsu_rdy), 32'd1);
    @(posedge clk); #1;
    chk("resume_we", 32'(we), 32'd1);
    chk("resume_waddr", 32'(waddr), 32'd10);
    chk("resume_wdata", wdata, 32'h2222_2222);

    // ---------------- reset mid-stream ----------------
    @(negedge clk);
    alu_v = 1'b1; alu_rd = 5'd4; alu_d = 32'h4444_4444;
    lsu_v = 1'b1; lsu_rd = 5'd9; lsu_d = 32'h3333_3333; f3 = 3'b010; off = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_pre_we", 32'(we), 32'd1);
    chk("mid_pre_cnt", 32'(scnt), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(we), 32'd0);
    chk("mid_rst_waddr", 32'(waddr), 32'd0);
    chk("mid_rst_wdata", wdata, 32'd0);
    chk("mid_rst_cnt", 32'(scnt), 32'd0);
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_post_we", 32'(we), 32'd0);
    chk("mid_post_cnt", 32'(scnt), 32'd0);

    // ---------------- randomized traffic ----------------
    a_pend = 1'b0; l_pend = 1'b0; lost = 0;
    h_addr = '0; h_data = '0;
    for (int c = 0; c < N_RAND; c++) begin
      @(negedge clk);
      if (!a_pend && $urandom_range(0, 9) < 6) begin
        a_pend = 1'b1;
        alu_rd = 5'($urandom_range(0, 31));
        alu_d  = $urandom;
      end
      if (!l_pend && $urandom_range(0, 9) < 7) begin
        l_pend = 1'b1;
        lsu_rd = 5'($urandom_range(0, 31));
        lsu_d  = $urandom;
        f3     = 3'($urandom_range(0, 7));
        off    = 2'($urandom_range(0, 3));
      end
      alu_v = a_pend;
      lsu_v = l_pend;
      #1;
      prio   = (lost >= STARVE_MAX);
      e_lrdy = !(prio && a_pend);
      e_ardy = !l_pend || prio;
      chk("rnd_alu_rdy", 32'(alu_rdy), 32'(e_ardy));
      chk("rnd_lsu_rdy", 32'(lsu_rdy), 32'(e_lrdy));
      chk("rnd_cnt", 32'(scnt), 32'(lost));
      l_win = l_pend && e_lrdy;
      a_win = a_pend && e_ardy && !l_win;
      if (l_win) begin
        h_addr = lsu_rd;
        h_data = fmt(lsu_d, f3, off);
      end else if (a_win) begin
        h_addr = alu_rd;
        h_data = alu_d;
      end
      exp_q.push_back({(l_win || a_win) && (h_addr != '0), h_addr, h_data});
      if (a_pend && !a_win) lost = (lost < STARVE_MAX) ? lost + 1 : lost;
      else lost = 0;
      if (l_win) l_pend = 1'b0;
      if (a_win) a_pend = 1'b0;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      chk("rnd_we", 32'(we), 32'(e[XLEN+ADDR_W]));
      chk("rnd_waddr", 32'(waddr), 32'(e[XLEN +: ADDR_W]));
      chk("rnd_wdata", wdata, e[XLEN-1:0]);
    end

    @(negedge clk);
    drive_idle();

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
